dram_fill_arbiter: RTL and testbench
====================================

Name: dram_fill_arbiter

Overview:
- Shares the DRAM-cache AXI write channel (AW/W/B) between two line-install requesters: the tag-compare fill port (write hit / write miss) and the refill path returning miss data from backing memory.
- Each accepted request becomes one single-beat write of {tag word, 512-bit line} to the line's direct-mapped slot.
- Tracks outstanding writes and reports write errors.

Parameters:
- ADDR_W, 64, request address width
- DATA_W, 512, line data width
- TAG_S, 64, tag word width stored beside the line
- ID_W, 16, AXI ID width
- TAG_W, 16, address tag field width, addr[63:48]
- INDEX_W, 10, address index field width, addr[47:38]
- SLOT_SHIFT, 7, log2 of bytes per DRAM slot
- WR_ID, 0, constant AWID
- MAX_OUTSTANDING, 4, max AW handshakes without matching B

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fill_valid_i  in  1  tag-compare install request
- fill_ready_o  out  1  fill request accepted
- fill_data_i  in  ADDR_W+DATA_W  {addr, line}; installed dirty
- refill_valid_i  in  1  memory refill install request
- refill_ready_o  out  1  refill request accepted
- refill_data_i  in  ADDR_W+DATA_W  {addr, line}; installed clean
- awid_o  out  ID_W  =WR_ID
- awaddr_o  out  ADDR_W  slot address
- awvalid_o  out  1  address valid
- awready_i  in  1  address ready
- wdata_o  out  TAG_S+DATA_W  {tag word, line}
- wstrb_o  out  (TAG_S+DATA_W)/8  all ones
- wlast_o  out  1  constant 1
- wvalid_o  out  1  data valid
- wready_i  in  1  data ready
- bid_i  in  ID_W  ignored
- bresp_i  in  2  write response
- bvalid_i  in  1  response valid
- bready_o  out  1  constant 1
- err_o  out  1  sticky, bresp_i != 0 seen
- idle_o  out  1  S_IDLE and zero outstanding

Behaviour:
- The clock is clk. Reset is rst, synchronous and active-high.
- Reset values:
  - state = S_IDLE; out_cnt = 0; rr_ptr = 0 (fill preferred).
  - awvalid_o, wvalid_o, fill_ready_o, refill_ready_o, err_o = 0.
  - idle_o = 1; bready_o = 1.
  - Reset asserted mid-transaction drops awvalid_o/wvalid_o on the next edge. The in-flight request is discarded.
- Tag word:
  - {1'b1 valid, dirty, addr[63:48], 46'b0}.
  - dirty = 1 for fill, 0 for refill.
- awaddr_o = zero-extended {addr[47:38], SLOT_SHIFT'b0}. Index 1 gives 0x80.
- State S_IDLE:
  - Grant is allowed when out_cnt < MAX_OUTSTANDING.
  - The ready signal is combinational and goes only to the selected requester.
  - Handshake (valid & ready) latches awaddr, wdata and the tag word into registers, then goes to S_SEND.
- Selection:
  - Only one requester valid: grant it.
  - Both valid, different index: grant the requester named by rr_ptr; rr_ptr flips to the other.
  - Both valid, same index: grant refill first regardless of rr_ptr, so the newer write data lands last. rr_ptr is set to fill.
- State S_SEND:
  - awvalid_o and wvalid_o are asserted from cycle N+1 after acceptance at cycle N.
  - Each channel drops independently after its handshake, recorded in aw_done / w_done.
  - Exit to S_IDLE on the cycle both are done; handshakes may complete in the same cycle or in either order.
  - Ready outputs are 0 in S_SEND.
  - Maximum throughput is one write per 2 cycles.
- out_cnt:
  - +1 on AW handshake; -1 on B handshake; simultaneous leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - A B handshake when out_cnt = 0 is ignored (no underflow).
- err_o sets on a B handshake with bresp_i != 0 and clears only on reset.
- Valid inputs may deassert without a handshake; no request is latched in that case.

Decomposition:
- Package dram_cache_pkg:
  - ADDR_W, DATA_W, TAG_S, TAG_W, INDEX_W, OFFSET_W, ID_W.
  - Tag word field positions (valid 63, dirty 62, tag 61:46, blank 45:0).
  - Tag-word build function.
  - State enum {S_IDLE, S_SEND}.
- One sub-module, fill_rr_select: combinational two-way round-robin plus same-index override, producing grant and next rr_ptr.

Test Plan:
- Fill only, addr {tag=3, index=1}, line=14, awready_i=wready_i=1 -> fill_ready_o at N; at N+1 awaddr_o=0x80, wdata_o tag word=0xC000_C000_0000_0000, line=14; idle_o returns 1 after B.
- Fill idx 2 and refill idx 5 both valid, rr_ptr=0 -> fill granted first, refill second; next simultaneous pair -> refill granted first.
- Fill and refill both at index 1 -> refill written first (dirty=0), then fill (dirty=1).
- wready_i held 0 for 3 cycles, awready_i=1 -> awvalid_o drops after 1 cycle, wvalid_o held 4 cycles with stable wdata_o; no new grant until W done.
- bvalid_i held 0, MAX_OUTSTANDING=4, continuous fills -> exactly 4 writes issued, then ready stays 0; one B pulse -> fifth write granted.
- bresp_i=2'b10 on a B -> err_o=1 and stays 1; rst pulse while in S_SEND -> awvalid_o=wvalid_o=0, out_cnt=0, err_o=0 next cycle.

Source files
------------

// File: rtl/dram_cache_pkg.sv
// Shared DRAM-cache definitions: address/line geometry, tag word layout and
// the install arbiter state encoding.
package dram_cache_pkg;

    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 512;
    localparam int TAG_S    = 64;
    localparam int TAG_W    = 16;
    localparam int INDEX_W  = 10;
    localparam int OFFSET_W = ADDR_W - TAG_W - INDEX_W;
    localparam int ID_W     = 16;

    localparam int TW_VALID_BIT = 63;
    localparam int TW_DIRTY_BIT = 62;
    localparam int TW_TAG_HI    = 61;
    localparam int TW_TAG_LO    = 46;
    localparam int TW_BLANK_W   = 46;

    localparam logic RR_FILL   = 1'b0;
    localparam logic RR_REFILL = 1'b1;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } arb_state_e;

    function automatic logic [TAG_S-1:0] build_tag_word(input logic [TAG_W-1:0] tag,
                                                        input logic             dirty);
        build_tag_word = {1'b1, dirty, tag, {TW_BLANK_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fill_rr_select.sv
// Two-way round-robin between fill and refill installs; a same-index collision
// always lets refill go first so the newer fill data overwrites it.
module fill_rr_select #(
    parameter int INDEX_W = 10
) (
    input  logic               fill_valid,
    input  logic               refill_valid,
    input  logic [INDEX_W-1:0] fill_index,
    input  logic [INDEX_W-1:0] refill_index,
    input  logic               rr_ptr,
    output logic               grant_fill,
    output logic               grant_refill,
    output logic               rr_ptr_nxt
);
    import dram_cache_pkg::*;

    always_comb begin
        grant_fill   = 1'b0;
        grant_refill = 1'b0;
        rr_ptr_nxt   = rr_ptr;
        if (fill_valid && refill_valid) begin
            if (fill_index == refill_index) begin
                grant_refill = 1'b1;
                rr_ptr_nxt   = RR_FILL;
            end else if (rr_ptr == RR_FILL) begin
                grant_fill = 1'b1;
                rr_ptr_nxt = RR_REFILL;
            end else begin
                grant_refill = 1'b1;
                rr_ptr_nxt   = RR_FILL;
            end
        end else if (fill_valid) begin
            grant_fill = 1'b1;
        end else if (refill_valid) begin
            grant_refill = 1'b1;
        end
    end

endmodule

// File: rtl/dram_fill_arbiter.sv
// Arbitrates fill and refill line installs onto one AXI write channel, issuing
// one single-beat {tag word, line} write per accepted request.
module dram_fill_arbiter #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 512,
    parameter int TAG_S           = 64,
    parameter int ID_W            = 16,
    parameter int TAG_W           = 16,
    parameter int INDEX_W         = 10,
    parameter int SLOT_SHIFT      = 7,
    parameter int WR_ID           = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fill_valid_i,
    output logic                         fill_ready_o,
    input  logic [ADDR_W+DATA_W-1:0]     fill_data_i,
    input  logic                         refill_valid_i,
    output logic                         refill_ready_o,
    input  logic [ADDR_W+DATA_W-1:0]     refill_data_i,
    output logic [ID_W-1:0]              awid_o,
    output logic [ADDR_W-1:0]            awaddr_o,
    output logic                         awvalid_o,
    input  logic                         awready_i,
    output logic [TAG_S+DATA_W-1:0]      wdata_o,
    output logic [(TAG_S+DATA_W)/8-1:0]  wstrb_o,
    output logic                         wlast_o,
    output logic                         wvalid_o,
    input  logic                         wready_i,
    input  logic [ID_W-1:0]              bid_i,
    input  logic [1:0]                   bresp_i,
    input  logic                         bvalid_i,
    output logic                         bready_o,
    output logic                         err_o,
    output logic                         idle_o
);
    import dram_cache_pkg::*;

    localparam int LINE_W  = TAG_S + DATA_W;
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int TAG_LO  = ADDR_W - TAG_W;
    localparam int IDX_LO  = ADDR_W - TAG_W - INDEX_W;
    localparam int SLOT_PAD = ADDR_W - INDEX_W - SLOT_SHIFT;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               rr_ptr_q, rr_ptr_d, rr_ptr_nxt;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic               err_q, err_d;

    logic [ADDR_W-1:0]  awaddr_p1;
    logic [LINE_W-1:0]  wdata_p1;

    logic               grant_fill, grant_refill, grant_ok;
    logic               fill_hs, refill_hs, accept;
    logic               aw_hs, w_hs, b_hs;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_line;
    logic [INDEX_W-1:0] sel_index;
    logic [ADDR_W-1:0]  slot_addr;
    logic [LINE_W-1:0]  install_word;

    fill_rr_select #(
        .INDEX_W (INDEX_W)
    ) u_rr_select (
        .fill_valid   (fill_valid_i),
        .refill_valid (refill_valid_i),
        .fill_index   (fill_data_i[DATA_W+IDX_LO +: INDEX_W]),
        .refill_index (refill_data_i[DATA_W+IDX_LO +: INDEX_W]),
        .rr_ptr       (rr_ptr_q),
        .grant_fill   (grant_fill),
        .grant_refill (grant_refill),
        .rr_ptr_nxt   (rr_ptr_nxt)
    );

    // Grant only from idle and while the B-response window has room.
    assign grant_ok       = (state_q == S_IDLE) && (out_cnt_q < MAX_CNT);
    assign fill_ready_o   = grant_ok && grant_fill;
    assign refill_ready_o = grant_ok && grant_refill;
    assign fill_hs        = fill_valid_i && fill_ready_o;
    assign refill_hs      = refill_valid_i && refill_ready_o;
    assign accept         = fill_hs || refill_hs;

    assign sel_addr     = grant_refill ? refill_data_i[DATA_W +: ADDR_W] : fill_data_i[DATA_W +: ADDR_W];
    assign sel_line     = grant_refill ? refill_data_i[DATA_W-1:0] : fill_data_i[DATA_W-1:0];
    assign sel_index    = sel_addr[IDX_LO +: INDEX_W];
    assign slot_addr    = {{SLOT_PAD{1'b0}}, sel_index, {SLOT_SHIFT{1'b0}}};
    assign install_word = {build_tag_word(sel_addr[TAG_LO +: TAG_W], grant_fill), sel_line};

    assign awvalid_o = (state_q == S_SEND) && !aw_done_q;
    assign wvalid_o  = (state_q == S_SEND) && !w_done_q;
    assign aw_hs     = awvalid_o && awready_i;
    assign w_hs      = wvalid_o && wready_i;
    // B with nothing outstanding is dropped so the counter cannot wrap.
    assign b_hs      = bvalid_i && (out_cnt_q != '0);

    assign awid_o   = ID_W'(WR_ID);
    assign awaddr_o = awaddr_p1;
    assign wdata_o  = wdata_p1;
    assign wstrb_o  = '1;
    assign wlast_o  = 1'b1;
    assign bready_o = 1'b1;
    assign err_o    = err_q;
    assign idle_o   = (state_q == S_IDLE) && (out_cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_SEND;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rr_ptr_d  = rr_ptr_nxt;
                end
            end
            S_SEND: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({aw_hs, b_hs})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
        err_d = err_q || (b_hs && (bresp_i != 2'b00));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            out_cnt_q <= '0;
            rr_ptr_q  <= RR_FILL;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_cnt_q <= out_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    // Stage p1: request captured on acceptance, held through the send.
    always_ff @(posedge clk) begin
        if (accept) begin
            awaddr_p1 <= slot_addr;
            wdata_p1  <= install_word;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{bid_i, sel_addr[IDX_LO-1:0]};

endmodule

// File: tb/tb_dram_fill_arbiter.sv
// Directed bench for dram_fill_arbiter: arbitration order, channel stalls,
// outstanding-write limit, error reporting and reset.
module tb_dram_fill_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         fill_valid_i, refill_valid_i;
    logic         fill_ready_o, refill_ready_o;
    logic [575:0] fill_data_i, refill_data_i;
    logic [15:0]  awid_o;
    logic [63:0]  awaddr_o;
    logic         awvalid_o, awready_i;
    logic [575:0] wdata_o;
    logic [71:0]  wstrb_o;
    logic         wlast_o, wvalid_o, wready_i;
    logic [15:0]  bid_i;
    logic [1:0]   bresp_i;
    logic         bvalid_i, bready_o, err_o, idle_o;

    int n_cmp  = 0;
    int n_fail = 0;

    dram_fill_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .fill_valid_i   (fill_valid_i),
        .fill_ready_o   (fill_ready_o),
        .fill_data_i    (fill_data_i),
        .refill_valid_i (refill_valid_i),
        .refill_ready_o (refill_ready_o),
        .refill_data_i  (refill_data_i),
        .awid_o         (awid_o),
        .awaddr_o       (awaddr_o),
        .awvalid_o      (awvalid_o),
        .awready_i      (awready_i),
        .wdata_o        (wdata_o),
        .wstrb_o        (wstrb_o),
        .wlast_o        (wlast_o),
        .wvalid_o       (wvalid_o),
        .wready_i       (wready_i),
        .bid_i          (bid_i),
        .bresp_i        (bresp_i),
        .bvalid_i       (bvalid_i),
        .bready_o       (bready_o),
        .err_o          (err_o),
        .idle_o         (idle_o)
    );

    always #5 clk = ~clk;

    function automatic logic [575:0] mk_req(input logic [15:0] tag, input logic [9:0] idx,
                                            input logic [511:0] line);
        mk_req = {tag, idx, 38'b0, line};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fill_valid_i = 1'b0;  refill_valid_i = 1'b0;
        fill_data_i = '0;     refill_data_i = '0;
        awready_i = 1'b1;     wready_i = 1'b1;
        bid_i = 16'h5a5a;     bresp_i = 2'b00;  bvalid_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (awvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_awvalid: got %b want 0", awvalid_o); end
        n_cmp++; if (wvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_wvalid: got %b want 0", wvalid_o); end
        n_cmp++; if ({fill_ready_o, refill_ready_o} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", {fill_ready_o, refill_ready_o}); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err_o); end
        n_cmp++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b want 1", idle_o); end
        n_cmp++; if ({bready_o, wlast_o} !== 2'b11) begin n_fail++; $display("FAIL rst_consts: got %b want 11", {bready_o, wlast_o}); end
        n_cmp++; if (awid_o !== 16'h0) begin n_fail++; $display("FAIL rst_awid: got %h want 0000", awid_o); end
        n_cmp++; if (wstrb_o !== {72{1'b1}}) begin n_fail++; $display("FAIL rst_wstrb: got %h want all ones", wstrb_o); end
    endtask

    task automatic test_fill_single();
        do_reset();
        fill_data_i = mk_req(16'd3, 10'd1, 512'd14);
        fill_valid_i = 1'b1;
        #1;
        n_cmp++; if ({fill_ready_o, refill_ready_o} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", {fill_ready_o, refill_ready_o}); end
        tick();
        fill_valid_i = 1'b0;
        n_cmp++; if ({awvalid_o, wvalid_o} !== 2'b11) begin n_fail++; $display("FAIL single_valids: got %b want 11", {awvalid_o, wvalid_o}); end
        n_cmp++; if (awaddr_o !== 64'h80) begin n_fail++; $display("FAIL single_awaddr: got %h want 80", awaddr_o); end
        n_cmp++; if (wdata_o[575:512] !== 64'hC000_C000_0000_0000) begin n_fail++; $display("FAIL single_tagword: got %h want c000c00000000000", wdata_o[575:512]); end
        n_cmp++; if (wdata_o[511:0] !== 512'd14) begin n_fail++; $display("FAIL single_line: got %0d want 14", wdata_o[511:0]); end
        n_cmp++; if (fill_ready_o !== 1'b0) begin n_fail++; $display("FAIL single_ready_send: got %b want 0", fill_ready_o); end
        tick();
        n_cmp++; if ({awvalid_o, wvalid_o, idle_o} !== 3'b000) begin n_fail++; $display("FAIL single_after: got %b want 000", {awvalid_o, wvalid_o, idle_o}); end
        bvalid_i = 1'b1;
        tick();
        bvalid_i = 1'b0;
        n_cmp++; if ({idle_o, err_o} !== 2'b10) begin n_fail++; $display("FAIL single_b_idle: got %b want 10", {idle_o, err_o}); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bvalid_i = 1'b1;
        fill_data_i   = mk_req(16'd2, 10'd2, 512'hF1);
        refill_data_i = mk_req(16'd5, 10'd5, 512'hE2);
        // first pair: rr_ptr starts at fill
        fill_valid_i = 1'b1; refill_valid_i = 1'b1;
        #1;
        n_cmp++; if ({fill_ready_o, refill_ready_o} !== 2'b10) begin n_fail++; $display("FAIL rr1_grant: got %b want 10", {fill_ready_o, refill_ready_o}); end
        tick();
        fill_valid_i = 1'b0;
        n_cmp++; if (awaddr_o !== 64'h100) begin n_fail++; $display("FAIL rr1_awaddr: got %h want 100", awaddr_o); end
        n_cmp++; if (wdata_o[575:512] !== 64'hC000_8000_0000_0000) begin n_fail++; $display("FAIL rr1_tagword: got %h want c000800000000000", wdata_o[575:512]); end
        tick();
        n_cmp++; if ({fill_ready_o, refill_ready_o} !== 2'b01) begin n_fail++; $display("FAIL rr1_second: got %b want 01", {fill_ready_o, refill_ready_o}); end
        tick();
        refill_valid_i = 1'b0;
        n_cmp++; if (awaddr_o !== 64'h280) begin n_fail++; $display("FAIL rr1_refill_awaddr: got %h want 280", awaddr_o); end
        n_cmp++; if (wdata_o[575:512] !== 64'h8001_4000_0000_0000) begin n_fail++; $display("FAIL rr1_refill_tag: got %h want 8001400000000000", wdata_o[575:512]); end
        tick();
        // second pair: refill now preferred
        fill_valid_i = 1'b1; refill_valid_i = 1'b1;
        #1;
        n_cmp++; if ({fill_ready_o, refill_ready_o} !== 2'b01) begin n_fail++; $display("FAIL rr2_grant: got %b want 01", {fill_ready_o, refill_ready_o}); end
        tick();
        refill_valid_i = 1'b0;
        n_cmp++; if (wdata_o[511:0] !== 512'hE2) begin n_fail++; $display("FAIL rr2_line: got %h want e2", wdata_o[511:0]); end
        tick();
        n_cmp++; if ({fill_ready_o, refill_ready_o} !== 2'b10) begin n_fail++; $display("FAIL rr2_second: got %b want 10", {fill_ready_o, refill_ready_o}); end
        tick();
        fill_valid_i = 1'b0;
        n_cmp++; if (awaddr_o !== 64'h100) begin n_fail++; $display("FAIL rr2_fill_awaddr: got %h want 100", awaddr_o); end
        tick();
        bvalid_i = 1'b0;
    endtask

    task automatic test_same_index();
        do_reset();
        bvalid_i = 1'b1;
        fill_data_i   = mk_req(16'd3, 10'd1, 512'hAA);
        refill_data_i = mk_req(16'd9, 10'd1, 512'hBB);
        fill_valid_i = 1'b1; refill_valid_i = 1'b1;
        #1;
        n_cmp++; if ({fill_ready_o, refill_ready_o} !== 2'b01) begin n_fail++; $display("FAIL same_grant: got %b want 01", {fill_ready_o, refill_ready_o}); end
        tick();
        refill_valid_i = 1'b0;
        n_cmp++; if (wdata_o[575:512] !== 64'h8002_4000_0000_0000) begin n_fail++; $display("FAIL same_refill_tag: got %h want 8002400000000000", wdata_o[575:512]); end
        n_cmp++; if (awaddr_o !== 64'h80) begin n_fail++; $display("FAIL same_awaddr: got %h want 80", awaddr_o); end
        tick();
        n_cmp++; if (fill_ready_o !== 1'b1) begin n_fail++; $display("FAIL same_fill_next: got %b want 1", fill_ready_o); end
        tick();
        fill_valid_i = 1'b0;
        n_cmp++; if (wdata_o !== {64'hC000_C000_0000_0000, 512'hAA}) begin n_fail++; $display("FAIL same_fill_word: got %h want c000c00000000000 + aa", wdata_o[575:512]); end
        tick();
        bvalid_i = 1'b0;
    endtask

    task automatic test_w_stall();
        logic [575:0] held;
        int wv_cycles;
        do_reset();
        awready_i = 1'b1; wready_i = 1'b0;
        fill_data_i = mk_req(16'h1234, 10'h3ff, 512'hDEAD_BEEF);
        fill_valid_i = 1'b1;
        tick();
        fill_valid_i = 1'b0;
        held = wdata_o;
        wv_cycles = 0;
        n_cmp++; if ({awvalid_o, wvalid_o} !== 2'b11) begin n_fail++; $display("FAIL stall_s1: got %b want 11", {awvalid_o, wvalid_o}); end
        n_cmp++; if (awaddr_o !== 64'h1FF80) begin n_fail++; $display("FAIL stall_awaddr: got %h want 1ff80", awaddr_o); end
        refill_data_i = mk_req(16'd1, 10'd7, 512'h77);
        refill_valid_i = 1'b1;
        if (wvalid_o === 1'b1) wv_cycles++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wvalid_o === 1'b1) wv_cycles++;
            n_cmp++; if (awvalid_o !== 1'b0) begin n_fail++; $display("FAIL stall_aw_drop%0d: got %b want 0", i, awvalid_o); end
            n_cmp++; if (wdata_o !== held) begin n_fail++; $display("FAIL stall_wdata%0d: got %h want %h", i, wdata_o[575:512], held[575:512]); end
            n_cmp++; if (refill_ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_nogrant%0d: got %b want 0", i, refill_ready_o); end
        end
        wready_i = 1'b1;
        tick();
        n_cmp++; if (wv_cycles != 4) begin n_fail++; $display("FAIL stall_wvalid_len: got %0d want 4", wv_cycles); end
        n_cmp++; if ({wvalid_o, refill_ready_o} !== 2'b01) begin n_fail++; $display("FAIL stall_release: got %b want 01", {wvalid_o, refill_ready_o}); end
        refill_valid_i = 1'b0;
        tick();
        n_cmp++; if (awvalid_o !== 1'b0) begin n_fail++; $display("FAIL stall_withdraw: got %b want 0", awvalid_o); end
    endtask

    task automatic test_outstanding();
        int grants;
        do_reset();
        fill_data_i = mk_req(16'd4, 10'd3, 512'h55);
        fill_valid_i = 1'b1;
        grants = 0;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (fill_ready_o === 1'b1) grants++;
            tick();
        end
        n_cmp++; if (grants != 4) begin n_fail++; $display("FAIL max_out_grants: got %0d want 4", grants); end
        n_cmp++; if ({fill_ready_o, idle_o} !== 2'b00) begin n_fail++; $display("FAIL max_out_blocked: got %b want 00", {fill_ready_o, idle_o}); end
        bvalid_i = 1'b1;
        tick();
        bvalid_i = 1'b0;
        n_cmp++; if (fill_ready_o !== 1'b1) begin n_fail++; $display("FAIL max_out_reopen: got %b want 1", fill_ready_o); end
        tick();
        fill_valid_i = 1'b0;
        n_cmp++; if (awvalid_o !== 1'b1) begin n_fail++; $display("FAIL max_out_fifth: got %b want 1", awvalid_o); end
    endtask

    task automatic test_error_reset();
        do_reset();
        bvalid_i = 1'b1;
        tick();
        bvalid_i = 1'b0;
        fill_data_i = mk_req(16'd6, 10'd2, 512'h66);
        fill_valid_i = 1'b1;
        tick();
        fill_valid_i = 1'b0;
        tick();
        n_cmp++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL err_pending: got %b want 0", idle_o); end
        bvalid_i = 1'b1; bresp_i = 2'b10;
        tick();
        bvalid_i = 1'b0; bresp_i = 2'b00;
        n_cmp++; if ({err_o, idle_o} !== 2'b11) begin n_fail++; $display("FAIL err_set: got %b want 11", {err_o, idle_o}); end
        tick();
        n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_o); end
        fill_valid_i = 1'b1;
        tick();
        fill_valid_i = 1'b0;
        tick();
        awready_i = 1'b0; wready_i = 1'b0;
        refill_data_i = mk_req(16'd8, 10'd4, 512'h88);
        refill_valid_i = 1'b1;
        tick();
        refill_valid_i = 1'b0;
        n_cmp++; if ({awvalid_o, wvalid_o} !== 2'b11) begin n_fail++; $display("FAIL err_inflight: got %b want 11", {awvalid_o, wvalid_o}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({awvalid_o, wvalid_o, err_o, idle_o} !== 4'b0001) begin n_fail++; $display("FAIL mid_reset: got %b want 0001", {awvalid_o, wvalid_o, err_o, idle_o}); end
        awready_i = 1'b1; wready_i = 1'b1;
        tick();
        n_cmp++; if ({awvalid_o, idle_o} !== 2'b01) begin n_fail++; $display("FAIL mid_reset_discard: got %b want 01", {awvalid_o, idle_o}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill_single();
        test_round_robin();
        test_same_index();
        test_w_stall();
        test_outstanding();
        test_error_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
